// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the five-stage pipeline control logic.
//   hz_state_t : hazard controller sequencing states (RUN, MEM_WAIT, ERROR)
//   REG_IDX_W  : architectural register index width
//   REG_ZERO   : index of x0, which never carries a true dependency
//   TMO_CNT_W  : width of the memory-handshake watchdog counter
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam int                   REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO  = 5'd0;

    // Wide enough for the largest supported MEM_TIMEOUT (65535).
    localparam int                   TMO_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational comparator that flags a load-use hazard: the instruction in EX
// is a load whose destination is a source the ID instruction actually reads.
// Writes to x0 are discarded by the register file, so they never create one.
//
// Ports:
//   id_rs1, id_rs2         in  source indices of the ID instruction
//   id_use_rs1, id_use_rs2 in  ID instruction reads the corresponding source
//   id_ex_memread          in  EX instruction is a load
//   id_ex_rd               in  destination index of the EX instruction
//   hit                    out load-use hazard present this cycle
// -----------------------------------------------------------------------------
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 id_ex_memread,
    input  logic [REG_IDX_W-1:0] id_ex_rd,
    output logic                 hit
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1 && (id_rs1 == id_ex_rd);
    assign rs2_match = id_use_rs2 && (id_rs2 == id_ex_rd);

    assign hit = id_ex_memread && (id_ex_rd != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central hazard and sequencing controller for the five-stage pipeline.
// Produces stall/flush strobes for PC, IF/ID, ID/EX and EX/MEM plus a bubble
// request for MEM/WB. Handles, highest priority first:
//   ERROR (memory watchdog fired) > memory wait > branch mispredict > load-use
// All strobes are combinational from the registered state and the current
// inputs so the pipeline registers act on them at the same clock edge.
//
// Optional build macro: HAZARD_PERF_CNT_EN adds the stall_cycles and
// flush_events saturating performance counters and their ports.
//
// Parameters:
//   MEM_TIMEOUT  max consecutive MEM_WAIT cycles before the fatal error (1..65535)
//   CNT_W        performance counter width
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   id_rs1, id_rs2             source indices of the ID instruction
//   id_use_rs1, id_use_rs2     ID instruction reads rs1 / rs2
//   id_ex_memread, id_ex_rd    EX instruction is a load / its destination
//   ex_mispredict              branch resolved in EX disagrees with prediction
//   mem_req, mem_ready         data-memory access in flight / completes now
//   pc_stall                   hold PC
//   if_id_stall, if_id_flush   IF/ID control
//   id_ex_stall, id_ex_flush   ID/EX control
//   ex_mem_stall, ex_mem_flush EX/MEM control
//   mem_wb_bubble              MEM/WB captures a NOP
//   mem_timeout                sticky fatal watchdog flag
//   stall_cycles, flush_events performance counters (HAZARD_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 id_ex_memread,
    input  logic [REG_IDX_W-1:0] id_ex_rd,
    input  logic                 ex_mispredict,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_stall,
    output logic                 if_id_stall,
    output logic                 if_id_flush,
    output logic                 id_ex_stall,
    output logic                 id_ex_flush,
    output logic                 ex_mem_stall,
    output logic                 ex_mem_flush,
    output logic                 mem_wb_bubble,
    output logic                 mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
`endif
);

    localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(MEM_TIMEOUT);

    hz_state_t              state;
    hz_state_t              state_nx;
    logic [TMO_CNT_W-1:0]   tmo_cnt;
    logic [TMO_CNT_W-1:0]   tmo_cnt_nx;
    logic                   lu_hit;
    logic                   mem_hold;

    load_use_detect u_load_use_detect (
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .id_ex_memread (id_ex_memread),
        .id_ex_rd      (id_ex_rd),
        .hit           (lu_hit)
    );

    // Memory stall this cycle: a new access that is not ready yet, or an
    // access already waiting whose ready has not arrived. Once waiting,
    // mem_req is not re-examined; the access is owned until ready.
    assign mem_hold = ((state == RUN) && mem_req && !mem_ready) ||
                      ((state == MEM_WAIT) && !mem_ready);

    // ------------------------------------------------------------------
    // State and watchdog registers
    // ------------------------------------------------------------------
    // NOTE: reset is in the sensitivity list so a reset in MEM_WAIT or ERROR
    // takes effect immediately, not at the next clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state   <= RUN;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= tmo_cnt_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and watchdog counter logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_nx   = state;
        tmo_cnt_nx = tmo_cnt;
        unique case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_nx   = MEM_WAIT;
                    tmo_cnt_nx = TMO_CNT_W'(1);
                end else begin
                    tmo_cnt_nx = '0;
                end
            end
            MEM_WAIT: begin
                // Ready on the limit cycle still completes the access.
                if (mem_ready) begin
                    state_nx   = RUN;
                    tmo_cnt_nx = '0;
                end else if (tmo_cnt == TMO_LIMIT) begin
                    state_nx   = ERROR;
                    tmo_cnt_nx = '0;
                end else begin
                    tmo_cnt_nx = tmo_cnt + TMO_CNT_W'(1);
                end
            end
            ERROR: begin
                // Sticky until reset; mem_ready is ignored.
                state_nx   = ERROR;
                tmo_cnt_nx = '0;
            end
            default: begin
                state_nx   = RUN;
                tmo_cnt_nx = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stall / flush outputs (Mealy)
    // ------------------------------------------------------------------
    // No branch ever drives a stall and a flush of the same register, and
    // EX/MEM is never flushed: on a mispredict the branch itself proceeds.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_wb_bubble = 1'b0;
        mem_timeout   = 1'b0;
        if (reset) begin
            // Quiet pipeline while reset is held, whatever the inputs say.
        end else if (state == ERROR) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
            mem_timeout   = 1'b1;
        end else if (mem_hold) begin
            // Freeze everything up to EX/MEM and feed NOPs into MEM/WB.
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (ex_mispredict) begin
            // Squash the two wrong-path instructions in IF/ID and ID/EX; this
            // also makes any load-use on the ID instruction irrelevant.
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end else if (lu_hit) begin
            // Hold the consumer in ID for one cycle and insert one bubble.
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_flush   = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    // if_id_flush is only ever raised by a mispredict, so it marks each
    // mispredict flush event exactly once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (if_id_flush && (flush_events != '1)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end
`endif

endmodule
